bcd_para_binario_seq: RTL and testbench
=======================================

BCD_PARA_BINARIO_SEQ -- requirements
Module: bcd_para_binario_seq

Interface
REQ-001 The block SHALL have parameter VALIDA_DIGITO, default 1: 1 = check each input digit for values above 9; 0 = no digit check.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Iniciar, input, 1 bit: conversion request, sampled on a rising edge of Clock.
REQ-005 The block SHALL have port Centenas, input, 4 bits: BCD hundreds digit.
REQ-006 The block SHALL have port Dezenas, input, 4 bits: BCD tens digit.
REQ-007 The block SHALL have port Unidades, input, 4 bits: BCD units digit.
REQ-008 The block SHALL have port Binario, output, 8 bits: registered conversion result.
REQ-009 The block SHALL have port Ocupado, output, 1 bit: high while a conversion is in progress.
REQ-010 The block SHALL have port Pronto, output, 1 bit: one-cycle pulse marking a new result.
REQ-011 The block SHALL have port Erro, output, 1 bit: registered error flag for the current result (overflow or invalid digit).

Function
REQ-012 The FSM SHALL have two states, OCIOSO and CONVERTE; Ocupado SHALL be 1 exactly when the state is CONVERTE.
REQ-013 In OCIOSO with Iniciar=1 at edge k, the block SHALL capture {Centenas,Dezenas,Unidades} into a 12-bit BCD register, clear an 8-bit binary shift register and the iteration counter, and enter CONVERTE.
REQ-014 In CONVERTE, each edge SHALL perform one reverse-double-dabble iteration.
REQ-015 Step 1 of each iteration SHALL shift the combined 20-bit {BCD,binary} register right by one bit.
REQ-016 Step 2 of each iteration SHALL subtract 3 from every resulting BCD digit that is greater than or equal to 8.
REQ-017 Exactly 8 iterations SHALL run, at edges k+1..k+8, with a 3-bit counter.
REQ-018 At edge k+8 the block SHALL load Binario from the shift register and set Pronto=1 for one cycle.
REQ-019 At edge k+8 Erro SHALL be set to 1 if the remaining BCD register is nonzero (input value > 255), else 0; the state SHALL return to OCIOSO.
REQ-020 On overflow, Binario SHALL hold the input value mod 256.
REQ-021 Latency SHALL be 8 cycles, from the accepting edge to the cycle in which Pronto is high.
REQ-022 With VALIDA_DIGITO=1 and any input digit > 9 at the accepting edge, the block SHALL skip conversion and stay in OCIOSO.
REQ-023 In that invalid-digit case, at edge k+1 the block SHALL set Binario=0x00 and Erro=1, and pulse Pronto for one cycle.
REQ-024 With VALIDA_DIGITO=0, out-of-range digits SHALL be processed arithmetically; Binario is then unspecified and Erro reflects overflow only.
REQ-025 Iniciar while in CONVERTE SHALL be ignored, with no queuing and no effect on the conversion in progress.
REQ-026 Iniciar in the same cycle as Pronto=1 SHALL be accepted, since the state is OCIOSO.
REQ-027 Input digits SHALL be don't-care except at the accepting edge.
REQ-028 Binario and Erro SHALL hold their values until the next Pronto pulse.
REQ-029 Pronto SHALL be 0 in every cycle except the single result cycle.

Reset
REQ-030 Reset_n=0 SHALL asynchronously force state OCIOSO, set Binario=0x00, Pronto=0, Erro=0, Ocupado=0, and clear the counter and internal registers.
REQ-031 A reset during CONVERTE SHALL abort the conversion and produce no Pronto pulse.
REQ-032 After Reset_n deasserts, the first rising edge with Iniciar=1 SHALL be accepted.

Structure
REQ-033 A shared package SHALL hold the state encoding (OCIOSO, CONVERTE), constant ITERACOES=8, and constant DIGITO_MAX=9.
REQ-034 The per-digit "subtract 3 if >= 8" correction SHALL be one combinational sub-module, corretor_bcd_menos3, instantiated three times.

Verification
REQ-035 Directed test: BCD 1,2,8 with Iniciar pulse -> Pronto 8 cycles later, Binario=0x80, Erro=0; Ocupado high for exactly 8 cycles.
REQ-036 Directed test: BCD 2,5,5 -> Binario=0xFF, Erro=0; BCD 0,0,0 -> Binario=0x00, Erro=0.
REQ-037 Directed test: BCD 2,5,6 -> Binario=0x00, Erro=1; BCD 9,9,9 -> Binario=0xE7, Erro=1.
REQ-038 Directed test: Dezenas=0xA with VALIDA_DIGITO=1 -> Pronto 1 cycle after accept, Binario=0x00, Erro=1, Ocupado never high.
REQ-039 Directed test: Iniciar with 0,4,2 re-asserted at cycle 3 of a running 1,0,0 conversion -> single result, Binario=0x64; back-to-back Iniciar on the Pronto cycle -> accepted.
REQ-040 Directed test: Reset_n=0 at cycle 4 of a conversion -> all outputs 0 immediately, no Pronto; next request 0,1,7 -> Binario=0x11.

Source files
------------

// File: rtl/bcd_para_binario_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
package bcd_para_binario_seq_pkg;

  typedef enum logic {
    OCIOSO   = 1'b0,
    CONVERTE = 1'b1
  } estado_t;

  // One reverse-double-dabble iteration per result bit.
  localparam int ITERACOES  = 8;
  localparam int DIGITO_MAX = 9;

endpackage

// File: rtl/bcd_para_binario_seq_corretor_bcd_menos3.sv
// Per-digit correction of reverse double dabble: after the right shift a
// digit >= 8 carried a borrowed 10 (seen as 8), so 3 brings it back to BCD.
module corretor_bcd_menos3 (
  input  logic [3:0] digito,
  output logic [3:0] corrigido
);

  assign corrigido = (digito >= 4'd8) ? (digito - 4'd3) : digito;

endmodule

// File: rtl/bcd_para_binario_seq.sv
// Sequential three-digit BCD to 8-bit binary converter (reverse double
// dabble, one iteration per clock). Values above 255 flag Erro and return
// the value mod 256; invalid digits short-circuit to an error result.
module bcd_para_binario_seq
  import bcd_para_binario_seq_pkg::*;
#(
  parameter int VALIDA_DIGITO = 1
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Iniciar,
  input  logic [3:0] Centenas,
  input  logic [3:0] Dezenas,
  input  logic [3:0] Unidades,
  output logic [7:0] Binario,
  output logic       Ocupado,
  output logic       Pronto,
  output logic       Erro
);

  estado_t     estado, estado_prox;
  logic [11:0] bcd_q;
  logic [7:0]  bin_q;
  logic [2:0]  cont_q;
  logic        erro_pend_q;

  logic [19:0] desloc;
  logic [11:0] bcd_corr;
  logic [7:0]  bin_prox;
  logic        invalido;
  logic        ultimo;

  // Step 1 of an iteration: shift the combined {BCD,binary} register right.
  assign desloc   = {bcd_q, bin_q} >> 1;
  assign bin_prox = desloc[7:0];

  // Step 2: fix each shifted BCD digit independently.
  for (genvar i = 0; i < 3; i++) begin : g_corr
    corretor_bcd_menos3 u_corr (
      .digito   (desloc[8 + 4*i +: 4]),
      .corrigido(bcd_corr[4*i +: 4])
    );
  end

  assign invalido = (VALIDA_DIGITO != 0) &&
                    ((Centenas > 4'(DIGITO_MAX)) ||
                     (Dezenas  > 4'(DIGITO_MAX)) ||
                     (Unidades > 4'(DIGITO_MAX)));
  assign ultimo   = (estado == CONVERTE) && (cont_q == 3'(ITERACOES - 1));
  assign Ocupado  = (estado == CONVERTE);

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) estado <= OCIOSO;
    else          estado <= estado_prox;
  end

  // Next state: invalid requests never leave OCIOSO; Iniciar is ignored
  // while converting.
  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:   if (Iniciar && !invalido) estado_prox = CONVERTE;
      CONVERTE: if (ultimo)               estado_prox = OCIOSO;
      default:  estado_prox = OCIOSO;
    endcase
  end

  // Datapath and result registers; Binario/Erro only change with Pronto.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      bcd_q       <= '0;
      bin_q       <= '0;
      cont_q      <= '0;
      erro_pend_q <= 1'b0;
      Binario     <= '0;
      Erro        <= 1'b0;
      Pronto      <= 1'b0;
    end else begin
      Pronto      <= 1'b0;
      erro_pend_q <= 1'b0;
      // Invalid digit seen last edge: publish the error result now.
      if (erro_pend_q) begin
        Binario <= '0;
        Erro    <= 1'b1;
        Pronto  <= 1'b1;
      end
      case (estado)
        OCIOSO: begin
          if (Iniciar) begin
            if (invalido) begin
              erro_pend_q <= 1'b1;
            end else begin
              bcd_q  <= {Centenas, Dezenas, Unidades};
              bin_q  <= '0;
              cont_q <= '0;
            end
          end
        end
        CONVERTE: begin
          bcd_q  <= bcd_corr;
          bin_q  <= bin_prox;
          cont_q <= cont_q + 3'd1;
          // Anything left in BCD after 8 shifts means the value exceeded 255.
          if (ultimo) begin
            Binario <= bin_prox;
            Erro    <= (bcd_corr != '0);
            Pronto  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_para_binario_seq.sv
// Directed self-checking bench for bcd_para_binario_seq.
module tb_bcd_para_binario_seq;

  logic       Clock;
  logic       Reset_n;
  logic       Iniciar;
  logic [3:0] Centenas, Dezenas, Unidades;
  logic [7:0] Binario;
  logic       Ocupado, Pronto, Erro;

  int n_assert = 0;
  int n_fail   = 0;

  bcd_para_binario_seq #(.VALIDA_DIGITO(1)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Iniciar (Iniciar),
    .Centenas(Centenas),
    .Dezenas (Dezenas),
    .Unidades(Unidades),
    .Binario (Binario),
    .Ocupado (Ocupado),
    .Pronto  (Pronto),
    .Erro    (Erro)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns at the negedge after the accepting edge.
  task automatic aceitar(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
    Iniciar  = 1'b1;
    Centenas = c;
    Dezenas  = d;
    Unidades = u;
    @(negedge Clock);
    Iniciar  = 1'b0;
    Centenas = 4'hx;
    Dezenas  = 4'hx;
    Unidades = 4'hx;
  endtask

  // Count negedges until Pronto, also counting cycles with Ocupado high.
  task automatic espera_pronto(output int lat, output int ocup);
    lat  = 0;
    ocup = 0;
    while (1) begin
      if (Ocupado) ocup++;
      if (Pronto || lat >= 20) break;
      @(negedge Clock);
      lat++;
    end
  endtask

  task automatic conta_pronto(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      if (Pronto) p++;
    end
  endtask

  initial begin
    int lat, ocup, p;
    Reset_n  = 1'b0;
    Iniciar  = 1'b0;
    Centenas = '0;
    Dezenas  = '0;
    Unidades = '0;
    @(negedge Clock);
    @(negedge Clock);
    chk("rst_binario", Binario, 8'h00);
    chk("rst_pronto",  Pronto,  1'b0);
    chk("rst_erro",    Erro,    1'b0);
    chk("rst_ocupado", Ocupado, 1'b0);
    Reset_n = 1'b1;
    @(negedge Clock);

    // 128: latency, busy window, single-cycle pulse, hold
    aceitar(4'd1, 4'd2, 4'd8);
    espera_pronto(lat, ocup);
    chk("128_lat",  lat,     8);
    chk("128_ocup", ocup,    8);
    chk("128_bin",  Binario, 8'h80);
    chk("128_erro", Erro,    1'b0);
    @(negedge Clock);
    chk("128_pronto_pulse", Pronto,  1'b0);
    chk("128_hold",         Binario, 8'h80);

    aceitar(4'd2, 4'd5, 4'd5);
    espera_pronto(lat, ocup);
    chk("255_lat",  lat,     8);
    chk("255_bin",  Binario, 8'hFF);
    chk("255_erro", Erro,    1'b0);

    aceitar(4'd0, 4'd0, 4'd0);
    espera_pronto(lat, ocup);
    chk("000_bin",  Binario, 8'h00);
    chk("000_erro", Erro,    1'b0);

    // Overflow: 256 -> 0x00, 999 -> 999-768 = 0xE7
    aceitar(4'd2, 4'd5, 4'd6);
    espera_pronto(lat, ocup);
    chk("256_bin",  Binario, 8'h00);
    chk("256_erro", Erro,    1'b1);

    aceitar(4'd9, 4'd9, 4'd9);
    espera_pronto(lat, ocup);
    chk("999_bin",  Binario, 8'hE7);
    chk("999_erro", Erro,    1'b1);

    // Invalid tens digit: immediate error result, never busy
    aceitar(4'd0, 4'hA, 4'd0);
    espera_pronto(lat, ocup);
    chk("inv_lat",  lat,     1);
    chk("inv_ocup", ocup,    0);
    chk("inv_bin",  Binario, 8'h00);
    chk("inv_erro", Erro,    1'b1);
    @(negedge Clock);
    chk("inv_pronto_pulse", Pronto, 1'b0);

    // Iniciar during a running conversion is ignored
    aceitar(4'd1, 4'd0, 4'd0);
    @(negedge Clock);
    @(negedge Clock);
    Iniciar  = 1'b1;
    Centenas = 4'd0;
    Dezenas  = 4'd4;
    Unidades = 4'd2;
    @(negedge Clock);
    Iniciar  = 1'b0;
    espera_pronto(lat, ocup);
    chk("ign_lat",  lat,     5);
    chk("ign_bin",  Binario, 8'h64);
    chk("ign_erro", Erro,    1'b0);
    conta_pronto(12, p);
    chk("ign_single_result", p, 0);

    // Back-to-back: request presented in the Pronto cycle is accepted
    aceitar(4'd0, 4'd1, 4'd5);
    espera_pronto(lat, ocup);
    chk("b2b_first_bin", Binario, 8'h0F);
    aceitar(4'd0, 4'd4, 4'd2);
    chk("b2b_accepted", Ocupado, 1'b1);
    espera_pronto(lat, ocup);
    chk("b2b_lat", lat,     8);
    chk("b2b_bin", Binario, 8'h2A);

    // Asynchronous reset in mid-conversion
    aceitar(4'd1, 4'd2, 4'd8);
    @(negedge Clock);
    @(negedge Clock);
    @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_ocupado", Ocupado, 1'b0);
    chk("arst_binario", Binario, 8'h00);
    chk("arst_erro",    Erro,    1'b0);
    chk("arst_pronto",  Pronto,  1'b0);
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    conta_pronto(12, p);
    chk("arst_no_pronto", p, 0);
    aceitar(4'd0, 4'd1, 4'd7);
    espera_pronto(lat, ocup);
    chk("post_rst_lat",  lat,     8);
    chk("post_rst_bin",  Binario, 8'h11);
    chk("post_rst_erro", Erro,    1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
